// File: rtl/ps2_key_decoder.sv
// Purpose : decodes PS/2 set-2 scan bytes into key events (ASCII, class, make code, E0 flag) and tracks shift.
// Latency : a mapped make byte strobed in cycle N is visible on key_valid in cycle N+1 when the FIFO was empty.
// Backpressure: events wait in a FIFO_DEPTH-entry FIFO; a push into a full FIFO with no pop is dropped and sets sticky overflow.
// Ports   : clk/rst (async active-high); rx_done/rx_data receiver strobe and byte;
//           key_valid/key_ready head-event handshake; key_ascii/key_class/key_code/key_ext head event fields;
//           shift_held current shift state; overflow sticky drop flag.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_ascii,
  output logic [1:0] key_class,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       shift_held,
  output logic       overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;
  localparam logic [7:0] LSHIFT  = 8'h12;
  localparam logic [7:0] RSHIFT  = 8'h59;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  typedef struct packed {
    logic [7:0] ascii;
    logic [1:0] cls;
    logic [7:0] code;
    logic       ext;
  } key_evt_t;

  // Uppercase ASCII for letter make codes, 0 for anything else.
  function automatic logic [7:0] letter_of(input logic [7:0] sc);
    case (sc)
      8'h1C: return 8'h41; 8'h32: return 8'h42; 8'h21: return 8'h43; 8'h23: return 8'h44;
      8'h24: return 8'h45; 8'h2B: return 8'h46; 8'h34: return 8'h47; 8'h33: return 8'h48;
      8'h43: return 8'h49; 8'h3B: return 8'h4A; 8'h42: return 8'h4B; 8'h4B: return 8'h4C;
      8'h3A: return 8'h4D; 8'h31: return 8'h4E; 8'h44: return 8'h4F; 8'h4D: return 8'h50;
      8'h15: return 8'h51; 8'h2D: return 8'h52; 8'h1B: return 8'h53; 8'h2C: return 8'h54;
      8'h3C: return 8'h55; 8'h2A: return 8'h56; 8'h1D: return 8'h57; 8'h22: return 8'h58;
      8'h35: return 8'h59; 8'h1A: return 8'h5A;
      default: return 8'h00;
    endcase
  endfunction

  state_t     state, state_nxt;
  key_evt_t   evt;
  logic       evt_vld;
  logic       shift_set, shift_clr;
  logic       is_make, ext_bit, is_shift;
  logic [7:0] letter;

  // Prefix FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Prefix FSM: next state, advancing only on received bytes.
  always_comb begin
    state_nxt = state;
    if (rx_done) begin
      case (state)
        S_IDLE: begin
          if (rx_data == PFX_EXT)      state_nxt = S_EXT;
          else if (rx_data == PFX_BRK) state_nxt = S_BRK;
          else                         state_nxt = S_IDLE;
        end
        S_EXT: begin
          if (rx_data == PFX_BRK)      state_nxt = S_EXT_BRK;
          else if (rx_data == PFX_EXT) state_nxt = S_EXT;
          else                         state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;  // break code consumed
      endcase
    end
  end

  // Prefix FSM: outputs -- event decode and shift updates.
  always_comb begin
    evt       = '0;
    evt_vld   = 1'b0;
    shift_set = 1'b0;
    shift_clr = 1'b0;
    letter    = letter_of(rx_data);
    ext_bit   = (state == S_EXT);
    is_shift  = (rx_data == LSHIFT) || (rx_data == RSHIFT);
    is_make   = rx_done && (state == S_IDLE || state == S_EXT) &&
                (rx_data != PFX_EXT) && (rx_data != PFX_BRK);
    evt.code  = rx_data;
    evt.ext   = ext_bit;
    if (is_make) begin
      if (!ext_bit) begin
        if (is_shift) begin
          shift_set = 1'b1;
        end else if (letter != 8'h00) begin
          evt_vld   = 1'b1;
          // shift_held is still the pre-byte value here.
          evt.ascii = shift_held ? letter : letter + 8'h20;
          evt.cls   = 2'b00;
        end else begin
          case (rx_data)
            8'h29: begin evt_vld = 1'b1; evt.ascii = 8'h20; evt.cls = 2'b00; end
            8'h5A: begin evt_vld = 1'b1; evt.ascii = 8'h0D; evt.cls = 2'b10; end
            8'h66: begin evt_vld = 1'b1; evt.ascii = 8'h08; evt.cls = 2'b11; end
            default: ;
          endcase
        end
      end else begin
        case (rx_data)
          8'h75, 8'h72, 8'h6B, 8'h74: begin evt_vld = 1'b1; evt.ascii = 8'h00; evt.cls = 2'b01; end
          default: ;
        endcase
      end
    end
    if (rx_done && state == S_BRK && is_shift) shift_clr = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            shift_held <= 1'b0;
    else if (shift_set) shift_held <= 1'b1;
    else if (shift_clr) shift_held <= 1'b0;
  end

  // Event FIFO.
  key_evt_t      mem [FIFO_DEPTH];
  key_evt_t      head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, push, pop;

  assign full = (count == CW'(FIFO_DEPTH));
  assign pop  = key_valid && key_ready;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push = evt_vld && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (evt_vld && full && !pop) overflow <= 1'b1;
    end
  end

  assign key_valid = (count != '0);
  assign head      = mem[rd_ptr];
  assign key_ascii = key_valid ? head.ascii : 8'h00;
  assign key_class = key_valid ? head.cls   : 2'b00;
  assign key_code  = key_valid ? head.code  : 8'h00;
  assign key_ext   = key_valid ? head.ext   : 1'b0;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Purpose : self-checking bench for ps2_key_decoder using an expected-event queue and an output monitor.
// Latency : checks key_valid one cycle after a mapped make byte.
// Backpressure: exercises key_ready low, FIFO full/overflow and simultaneous push/pop at full.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       key_ready = 1'b1;
  logic       key_valid;
  logic [7:0] key_ascii;
  logic [1:0] key_class;
  logic [7:0] key_code;
  logic       key_ext;
  logic       shift_held;
  logic       overflow;

  typedef struct packed {
    logic [7:0] ascii;
    logic [1:0] cls;
    logic [7:0] code;
    logic       ext;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ps2_key_decoder #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_ascii  (key_ascii),
    .key_class  (key_class),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .shift_held (shift_held),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input logic [7:0] a, input logic [1:0] c, input logic [7:0] code, input logic e);
    exp_t x;
    x.ascii = a; x.cls = c; x.code = code; x.ext = e;
    exp_q.push_back(x);
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || key_valid) && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: compares every accepted head event against the scoreboard and
  // verifies the event outputs are zero whenever nothing is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (key_valid && key_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %0h expected none at %0t",
                     {key_ascii, key_class, key_code, key_ext}, $time);
          end else begin
            e = exp_q.pop_front();
            check("event", {13'd0, key_ascii, key_class, key_code, key_ext}, {13'd0, e});
          end
        end else if (!key_valid) begin
          check("idle_outputs_zero", {13'd0, key_ascii, key_class, key_code, key_ext}, 32'd0);
        end
      end
    end
  end

  initial begin
    // Reset state
    #2;
    check("rst_key_valid", key_valid, 0);
    check("rst_shift", shift_held, 0);
    check("rst_overflow", overflow, 0);
    check("rst_ascii", key_ascii, 0);
    @(posedge clk); #3;
    rst = 1'b0;

    // Make/break of 'a': exactly one event, visible one cycle after the make.
    expect_ev(8'h61, 2'b00, 8'h1C, 1'b0);
    send(8'h1C);
    check("valid_latency", key_valid, 1);
    check("first_ascii", key_ascii, 8'h61);
    send(8'hF0); send(8'h1C);

    // Shifted and unshifted B
    expect_ev(8'h42, 2'b00, 8'h32, 1'b0);
    send(8'h12);
    check("shift_set", shift_held, 1);
    send(8'h32); send(8'hF0); send(8'h32);
    check("shift_still_held", shift_held, 1);
    send(8'hF0); send(8'h12);
    check("shift_cleared", shift_held, 0);
    expect_ev(8'h62, 2'b00, 8'h32, 1'b0);
    send(8'h32);

    // Navigation, extended break, enter, backspace, space, up
    expect_ev(8'h00, 2'b01, 8'h6B, 1'b1);
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h6B);
    expect_ev(8'h0D, 2'b10, 8'h5A, 1'b0); send(8'h5A);
    expect_ev(8'h08, 2'b11, 8'h66, 1'b0); send(8'h66);
    expect_ev(8'h20, 2'b00, 8'h29, 1'b0); send(8'h29);
    expect_ev(8'h00, 2'b01, 8'h75, 1'b1); send(8'hE0); send(8'h75);

    // Right shift gives uppercase Z; key repeat gives one event per make
    send(8'h59);
    check("rshift_set", shift_held, 1);
    expect_ev(8'h5A, 2'b00, 8'h1A, 1'b0); send(8'h1A);
    expect_ev(8'h5A, 2'b00, 8'h1A, 1'b0); send(8'h1A);
    send(8'hF0); send(8'h59);
    check("rshift_clr", shift_held, 0);

    // Unmapped bytes: no events, shift unchanged
    send(8'h05); send(8'hE1); send(8'hE0); send(8'h12);
    check("fake_shift_ignored", shift_held, 0);
    send(8'hE0); send(8'h1C);
    drain("drain_basic");

    // Full FIFO with backpressure
    key_ready = 1'b0;
    expect_ev(8'h61, 2'b00, 8'h1C, 1'b0); send(8'h1C);
    expect_ev(8'h62, 2'b00, 8'h32, 1'b0); send(8'h32);
    expect_ev(8'h63, 2'b00, 8'h21, 1'b0); send(8'h21);
    expect_ev(8'h64, 2'b00, 8'h23, 1'b0); send(8'h23);
    check("no_overflow_at_full", overflow, 0);
    send(8'h24);  // dropped
    check("overflow_set", overflow, 1);
    check("full_head", key_ascii, 8'h61);
    // Push coincident with pop while full
    expect_ev(8'h66, 2'b00, 8'h2B, 1'b0);
    @(posedge clk); #1;
    key_ready = 1'b1;
    rx_done   = 1'b1;
    rx_data   = 8'h2B;
    @(posedge clk); #1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    check("overflow_kept", overflow, 1);
    drain("drain_full");
    check("overflow_sticky", overflow, 1);

    // Reset after a lone E0 with events queued
    key_ready = 1'b0;
    send(8'h12);
    check("shift_before_rst", shift_held, 1);
    send(8'h1C); send(8'h32);
    check("queued_valid", key_valid, 1);
    send(8'hE0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", key_valid, 0);
    check("rst_async_overflow", overflow, 0);
    check("rst_async_shift", shift_held, 0);
    exp_q.delete();
    @(posedge clk); #3;
    rst = 1'b0;
    key_ready = 1'b1;
    expect_ev(8'h61, 2'b00, 8'h1C, 1'b0);
    send(8'h1C);
    check("post_rst_ext", key_ext, 0);
    check("post_rst_ascii", key_ascii, 8'h61);
    drain("drain_rst1");

    // Reset after a lone F0: next byte is a make, not a break
    send(8'hF0);
    #2 rst = 1'b1;
    @(posedge clk); #3;
    rst = 1'b0;
    expect_ev(8'h61, 2'b00, 8'h1C, 1'b0);
    send(8'h1C);
    check("post_rst_brk_valid", key_valid, 1);
    drain("drain_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
